// File: rtl/serial_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : serial_deserializer
// Description : Serial-to-parallel word assembler with frame alignment,
//               valid/ready output holding register and sticky overrun flag.
//               Optional even-parity check enabled by defining PARITY_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             start,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             overrun,
  output logic             parity_err
);

`ifdef PARITY_CHECK_EN
  localparam int c_FRAME_LEN = WIDTH + 1;
`else
  localparam int c_FRAME_LEN = WIDTH;
`endif
  localparam int c_CNT_W = $clog2(WIDTH + 1);
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_FRAME_LEN - 1);

  localparam logic [0:0] c_IDLE  = 1'b0;
  localparam logic [0:0] c_SHIFT = 1'b1;

  logic [0:0]         r_state;
  logic [c_CNT_W-1:0] r_count;
  logic [WIDTH-1:0]   r_shift;
  logic [WIDTH-1:0]   r_dout;
  logic               r_dout_valid;
  logic               r_overrun;

  logic               w_take;
  logic               w_last;
  logic               w_complete;
  logic               w_load;
  logic [WIDTH-1:0]   w_shifted;
  logic [WIDTH-1:0]   w_word;

  // The bit presented on a start cycle is discarded, so start blocks sampling.
  assign w_take     = (r_state == c_SHIFT) && sin_valid && !start;
  assign w_last     = (r_count == c_LAST);
  assign w_complete = w_take && w_last;
  assign w_load     = w_complete && (!r_dout_valid || dout_ready);

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_shifted = {r_shift[WIDTH-2:0], sin};
    end else begin : g_lsb_first
      assign w_shifted = {sin, r_shift[WIDTH-1:1]};
    end
  endgenerate

`ifdef PARITY_CHECK_EN
  // The final frame bit is parity; the data bits are already in r_shift.
  assign w_word = r_shift;
`else
  assign w_word = w_shifted;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= c_IDLE;
      r_count      <= '0;
      r_shift      <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      if (start) begin
        r_state <= c_SHIFT;
        r_count <= '0;
        r_shift <= '0;
      end else if (w_take) begin
        if (w_last) begin
          r_count <= '0;
          r_shift <= '0;
        end else begin
          r_count <= r_count + c_CNT_W'(1);
          r_shift <= w_shifted;
        end
      end

      if (w_load) begin
        r_dout       <= w_word;
        r_dout_valid <= 1'b1;
      end else if (r_dout_valid && dout_ready) begin
        r_dout_valid <= 1'b0;
      end

      if (start) begin
        r_overrun <= 1'b0;
      end else if (w_complete && r_dout_valid && !dout_ready) begin
        r_overrun <= 1'b1;
      end
    end
  end

`ifdef PARITY_CHECK_EN
  logic r_parity_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_parity_err <= 1'b0;
    end else if (start) begin
      r_parity_err <= 1'b0;
    end else if (w_complete && (^{r_shift, sin})) begin
      r_parity_err <= 1'b1;
    end
  end

  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign overrun    = r_overrun;
  assign busy       = (r_state == c_SHIFT) && (r_count != '0);

endmodule
`default_nettype wire
